score_lives_controller: RTL and testbench

- Owns the game's score and lives state and arbitrates update requests from the collision logic: alien hit, player hit, new game.
- After every update it runs a multi-cycle binary-to-BCD conversion and latches stable display digits.
- It drives a time-multiplexed 3-digit seven-segment scan (score ones, score tens, lives) from the clk_display enable.
- It sits between the game FSM/collision detectors and the board's seven-segment pins.

---
 rtl/score_lives_controller.sv | 155 +++++++++++++++
 tb/tb_score_lives_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_lives_controller.sv
// score_lives_controller: score/lives bookkeeping with request arbitration, BCD split and 3-digit seven-segment scan
//
// Ports:
//   clk            system clock
//   arst           asynchronous active-low reset
//   clk_display    one-cycle scan enable, synchronous to clk
//   new_game       level request: reload score and lives
//   alien_hit_req  level request, held until alien_hit_ack
//   player_hit_req level request, held until player_hit_ack
//   *_ack          one-cycle grant pulses (high during the update cycle)
//   score, lives   current binary score and lives
//   game_over      high while lives == 0
//   busy           high while an update/conversion is in flight
//   an             active-low anodes: [0] score ones, [1] score tens, [2] lives
//   seg            active-low segments {g,f,e,d,c,b,a}
module score_lives_controller #(
  parameter int LIVES_INIT = 3,
  parameter int SCORE_MAX = 99,
  parameter int ALIEN_POINTS = 1
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       clk_display,
  input  logic       new_game,
  input  logic       alien_hit_req,
  input  logic       player_hit_req,
  output logic       new_game_ack,
  output logic       alien_hit_ack,
  output logic       player_hit_ack,
  output logic [6:0] score,
  output logic [3:0] lives,
  output logic       game_over,
  output logic       busy,
  output logic [2:0] an,
  output logic [6:0] seg
);

  typedef enum logic [1:0] {IDLE, UPDATE, CONVERT, LATCH} state_t;

  state_t     state, state_nx;
  logic       g_new, g_alien, g_player;
  logic       ptr_player;
  logic [7:0] sum;
  logic [6:0] score_upd;
  logic [3:0] lives_upd;
  logic       go_upd;
  logic [6:0] rem;
  logic [3:0] tens_acc;
  logic [3:0] ones_d, tens_d, lives_d;
  logic [1:0] cnt;
  logic [2:0] scan_an;
  logic [6:0] scan_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge arst)
    if (!arst) state <= IDLE;
    else state <= state_nx;

  // new_game always wins; between the two hits the pointer breaks ties only
  // when both are requesting, a lone requester is granted directly.
  always_comb begin
    g_new = state == IDLE && new_game;
    g_alien = state == IDLE && !new_game && alien_hit_req && (!player_hit_req || !ptr_player);
    g_player = state == IDLE && !new_game && player_hit_req && (!alien_hit_req || ptr_player);
    state_nx = state == IDLE ? ((g_new || g_alien || g_player) ? UPDATE : IDLE) :
               state == UPDATE ? CONVERT :
               state == CONVERT ? (rem >= 7'd10 ? CONVERT : LATCH) : IDLE;
  end

  // The ack registers double as the record of which update is in flight,
  // since each is high exactly during the UPDATE cycle.
  always_comb begin
    sum = {1'b0, score} + 8'(ALIEN_POINTS);
    score_upd = new_game_ack ? 7'd0 :
                (alien_hit_ack && !game_over) ? (sum > 8'(SCORE_MAX) ? 7'(SCORE_MAX) : sum[6:0]) : score;
    lives_upd = new_game_ack ? 4'(LIVES_INIT) :
                player_hit_ack ? (lives == 4'd0 ? 4'd0 : lives - 4'd1) : lives;
    go_upd = new_game_ack ? 1'b0 : player_hit_ack ? lives_upd == 4'd0 : game_over;
  end

  assign busy = state != IDLE;

  always_ff @(posedge clk or negedge arst)
    if (!arst) begin
      new_game_ack <= 1'b0;
      alien_hit_ack <= 1'b0;
      player_hit_ack <= 1'b0;
      ptr_player <= 1'b0;
      score <= 7'd0;
      lives <= 4'(LIVES_INIT);
      game_over <= 1'b0;
      rem <= 7'd0;
      tens_acc <= 4'd0;
      ones_d <= 4'd0;
      tens_d <= 4'd0;
      lives_d <= 4'(LIVES_INIT);
    end else begin
      new_game_ack <= g_new;
      alien_hit_ack <= g_alien;
      player_hit_ack <= g_player;
      if (g_alien) ptr_player <= 1'b1;
      else if (g_player || (state == UPDATE && new_game_ack)) ptr_player <= 1'b0;
      if (state == UPDATE) begin
        score <= score_upd;
        lives <= lives_upd;
        game_over <= go_upd;
        rem <= score_upd;
        tens_acc <= 4'd0;
      end
      if (state == CONVERT && rem >= 7'd10) begin
        rem <= rem - 7'd10;
        tens_acc <= tens_acc + 4'd1;
      end
      if (state == LATCH) begin
        ones_d <= rem[3:0];
        tens_d <= tens_acc;
        lives_d <= lives;
      end
    end

  // Digit registers update on the LATCH edge, so a scan on that same edge
  // still shows the previous, complete value.
  always_comb begin
    scan_an = cnt == 2'd0 ? 3'b110 : cnt == 2'd1 ? 3'b101 : 3'b011;
    scan_seg = cnt == 2'd0 ? seg7(ones_d) :
               cnt == 2'd1 ? (tens_d == 4'd0 ? 7'b1111111 : seg7(tens_d)) : seg7(lives_d);
  end

  always_ff @(posedge clk or negedge arst)
    if (!arst) begin
      cnt <= 2'd0;
      an <= 3'b111;
      seg <= 7'b1111111;
    end else if (clk_display) begin
      an <= scan_an;
      seg <= scan_seg;
      cnt <= cnt == 2'd2 ? 2'd0 : cnt + 2'd1;
    end

endmodule

// File: tb/tb_score_lives_controller.sv
// tb_score_lives_controller: directed stimulus with a transaction-level reference model checked every cycle
module tb_score_lives_controller;

  localparam int LI = 3;
  localparam int SM = 99;
  localparam int AP = 1;

  logic       clk = 0, arst = 0, clk_display = 0, new_game = 0, alien_hit_req = 0, player_hit_req = 0;
  logic       new_game_ack, alien_hit_ack, player_hit_ack, game_over, busy;
  logic [6:0] score, seg;
  logic [3:0] lives;
  logic [2:0] an;

  int errors = 0, checks = 0;

  score_lives_controller #(.LIVES_INIT(LI), .SCORE_MAX(SM), .ALIEN_POINTS(AP)) dut (
    .clk(clk), .arst(arst), .clk_display(clk_display), .new_game(new_game),
    .alien_hit_req(alien_hit_req), .player_hit_req(player_hit_req),
    .new_game_ack(new_game_ack), .alien_hit_ack(alien_hit_ack), .player_hit_ack(player_hit_ack),
    .score(score), .lives(lives), .game_over(game_over), .busy(busy), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  logic [6:0] codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int m_score, m_lives, m_go, m_ones, m_tens, m_ld, m_ptr_player, m_left, m_cnt, m_an, m_seg;
  int m_ack, m_pend, n_score, n_lives, n_go;

  function automatic int disp(int v, bit blank0);
    return (blank0 && v == 0) ? 7'h7f : int'(codes[v]);
  endfunction

  // Model: a grant fixes the new score/lives at once, exposes them one edge
  // later, and the display digits appear 3 + score/10 edges after the grant.
  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      m_score = 0; m_lives = LI; m_go = 0; m_ones = 0; m_tens = 0; m_ld = LI;
      m_ptr_player = 0; m_left = 0; m_cnt = 0; m_an = 7; m_seg = 7'h7f; m_ack = 0; m_pend = 0;
    end else begin
      if (clk_display) begin
        m_an = m_cnt == 0 ? 6 : m_cnt == 1 ? 5 : 3;
        m_seg = m_cnt == 0 ? disp(m_ones, 0) : m_cnt == 1 ? disp(m_tens, 1) : disp(m_ld, 0);
        m_cnt = (m_cnt + 1) % 3;
      end
      m_ack = 0;
      if (m_pend) begin
        m_score = n_score; m_lives = n_lives; m_go = n_go; m_pend = 0;
      end
      if (m_left == 0) begin
        n_score = m_score; n_lives = m_lives; n_go = m_go;
        if (new_game) begin
          m_ack = 4; n_score = 0; n_lives = LI; n_go = 0; m_ptr_player = 0;
        end else if (alien_hit_req && (!player_hit_req || !m_ptr_player)) begin
          m_ack = 2; m_ptr_player = 1;
          if (!m_go) n_score = (m_score + AP > SM) ? SM : m_score + AP;
        end else if (player_hit_req) begin
          m_ack = 1; m_ptr_player = 0;
          n_lives = m_lives > 0 ? m_lives - 1 : 0;
          n_go = n_lives == 0;
        end
        if (m_ack != 0) begin
          m_left = 3 + n_score / 10;
          m_pend = 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_ones = m_score % 10; m_tens = m_score / 10; m_ld = m_lives;
        end
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (arst) begin
      chk("score", score, m_score);
      chk("lives", lives, m_lives);
      chk("game_over", game_over, m_go);
      chk("busy", busy, m_left > 0);
      chk("acks", {new_game_ack, alien_hit_ack, player_hit_ack}, m_ack);
      chk("an", an, m_an);
      chk("seg", seg, m_seg);
    end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin tick(); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  function automatic logic ack_of(int w);
    return w == 0 ? new_game_ack : w == 1 ? alien_hit_ack : player_hit_ack;
  endfunction

  task automatic set_req(int w, logic v);
    if (w == 0) new_game = v;
    else if (w == 1) alien_hit_req = v;
    else player_hit_req = v;
  endtask

  task automatic hit(int w);
    int n = 0;
    set_req(w, 1);
    do begin tick(); n++; end while (!ack_of(w) && n < 40);
    chk("ack_timeout", ack_of(w), 1);
    set_req(w, 0);
    wait_idle();
  endtask

  task automatic show(logic [2:0] target, logic [6:0] exp_seg, string nm);
    int n = 0;
    do begin clk_display = 1; tick(); clk_display = 0; n++; end while (an != target && n < 3);
    chk({nm, "_an"}, an, target);
    chk({nm, "_seg"}, seg, exp_seg);
  endtask

  task automatic wait_any_ack(output int w);
    int n = 0;
    w = -1;
    do begin
      tick(); n++;
      if (new_game_ack) w = 0; else if (alien_hit_ack) w = 1; else if (player_hit_ack) w = 2;
    end while (w < 0 && n < 40);
  endtask

  initial begin
    int w, nb;
    tick(2);
    chk("rst_an", an, 3'b111);
    chk("rst_seg", seg, 7'h7f);
    chk("rst_lives", lives, LI);
    arst = 1;
    tick(2);
    show(3'b110, 7'b1000000, "scan_ones0");
    show(3'b101, 7'b1111111, "scan_tens_blank");
    show(3'b011, 7'b0110000, "scan_lives3");

    alien_hit_req = 1;
    tick();
    chk("t2_ack", alien_hit_ack, 1);
    alien_hit_req = 0;
    nb = 0;
    while (busy && nb < 40) begin nb++; tick(); end
    chk("t2_busy_cycles", nb, 3);
    chk("t2_score", score, 1);
    show(3'b110, 7'b1111001, "t2_ones1");

    repeat (97) hit(1);
    chk("t3_score98", score, 98);
    for (int i = 0; i < 2; i++) begin
      alien_hit_req = 1;
      tick();
      alien_hit_req = 0;
      nb = 0;
      while (busy && nb < 40) begin nb++; tick(); end
      chk("t3_busy_cycles", nb, 12);
      chk("t3_score99", score, 99);
    end
    show(3'b101, 7'b0010000, "t3_tens9");
    show(3'b110, 7'b0010000, "t3_ones9");

    hit(0);
    for (int i = 0; i < 4; i++) begin
      alien_hit_req = 1; player_hit_req = 1; clk_display = 1;
      wait_any_ack(w);
      chk("rr_first_alien", w, 1);
      alien_hit_req = 0;
      wait_any_ack(w);
      chk("rr_then_player", w, 2);
      player_hit_req = 0; clk_display = 0;
      wait_idle();
    end

    new_game = 1; alien_hit_req = 1; player_hit_req = 1;
    wait_any_ack(w);
    chk("ng_wins", w, 0);
    new_game = 0;
    wait_any_ack(w);
    chk("pending_alien", w, 1);
    alien_hit_req = 0;
    wait_any_ack(w);
    chk("pending_player", w, 2);
    player_hit_req = 0;
    wait_idle();

    hit(0);
    repeat (3) hit(2);
    chk("go_lives0", lives, 0);
    chk("go_flag", game_over, 1);
    hit(2);
    chk("go_lives_sat", lives, 0);
    hit(1);
    chk("go_score_frozen", score, 0);
    show(3'b011, 7'b1000000, "go_lives_digit");
    hit(0);
    chk("ng_score", score, 0);
    chk("ng_lives", lives, LI);
    chk("ng_go", game_over, 0);

    repeat (56) hit(1);
    alien_hit_req = 1;
    tick();
    alien_hit_req = 0;
    tick(2);
    chk("mid_busy", busy, 1);
    chk("mid_score57", score, 57);
    #2 arst = 0;
    #1;
    chk("arst_score", score, 0);
    chk("arst_lives", lives, LI);
    chk("arst_go", game_over, 0);
    chk("arst_busy", busy, 0);
    chk("arst_acks", {new_game_ack, alien_hit_ack, player_hit_ack}, 0);
    chk("arst_an", an, 3'b111);
    chk("arst_seg", seg, 7'h7f);
    tick();
    arst = 1;
    tick(4);
    show(3'b110, 7'b1000000, "post_rst_ones");
    show(3'b101, 7'b1111111, "post_rst_tens");
    show(3'b011, 7'b0110000, "post_rst_lives");
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
